// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the run-control / state-dump engine.
//   state_e       : controller states
//   DK_*          : dump beat kinds carried on dump_kind_o
//   HC_*          : bit positions inside halt_cause_o
package cpu_dbg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_TDUMP = 3'd2,
      ST_RDUMP = 3'd3,
      ST_MDUMP = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam logic [1:0] DK_TRACE = 2'd0;
   localparam logic [1:0] DK_REG   = 2'd1;
   localparam logic [1:0] DK_MEM   = 2'd2;

   localparam int HC_BUDGET = 0;
   localparam int HC_BKPT   = 1;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Dump stream port of cpu_run_monitor (valid/ready).
//   dump_valid_o  : beat valid          (master -> slave)
//   dump_ready_i  : consumer accepts    (slave  -> master)
//   dump_kind_o   : DK_TRACE / DK_REG / DK_MEM
//   dump_index_o  : beat index within its kind
//   dump_data_o   : {pc, instr} for trace, {zeros, word} otherwise
interface cpu_run_monitor_if #(
   parameter int DATA_W = 32
) ();
   logic                  dump_valid_o;
   logic                  dump_ready_i;
   logic [1:0]            dump_kind_o;
   logic [15:0]           dump_index_o;
   logic [2*DATA_W-1:0]   dump_data_o;

   modport master (
      output dump_valid_o, dump_kind_o, dump_index_o, dump_data_o,
      input  dump_ready_i
   );

   modport slave (
      input  dump_valid_o, dump_kind_o, dump_index_o, dump_data_o,
      output dump_ready_i
   );
endinterface

// File: rtl/trace_ring.sv
// Circular capture buffer with saturating entry count.
//   clk, rst : clock, synchronous active-high reset (clears pointer/count)
//   clr      : clear pointer/count (new run)
//   we,wdata : write one entry at the write pointer
//   rd_idx   : read offset counted from the oldest live entry
//   rdata    : combinational read data
//   count    : live entries, saturates at DEPTH
module trace_ring #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 64,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             we,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    rd_idx,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (we) begin
         wr_ptr <= wr_ptr + 1'b1;   // power-of-two depth: wraps naturally
         if (count != CW'(DEPTH))
            count <= count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_ptr] <= wdata;
   end

   // Oldest entry sits count slots behind the write pointer; when full the
   // low bits of count are zero, so the oldest is the write pointer itself.
   assign rd_ptr = wr_ptr - count[AW-1:0] + rd_idx;
   assign rdata  = mem[rd_ptr];

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control and state-dump engine beside the MIPS core.
// Arms on start, lets the core run while tracing {pc, instr}, halts on the
// cycle budget or a PC breakpoint, then streams trace, register file and
// watched memory words over the dump port.
//   clk, rst            : clock, synchronous active-high reset
//   start               : arm a run (IDLE/DONE only)
//   halt_pc_en, halt_pc : PC breakpoint, sampled live during RUN
//   pc_i, instr_i       : core fetch stream
//   cpu_stall_o         : core freeze, low only in RUN
//   rf_raddr_o/rdata_i  : register-file debug read port (combinational)
//   dm_raddr_o/rdata_i  : data-memory debug read port (combinational)
//   watch_addr_i        : NUM_WATCH packed byte addresses
//   dump                : dump stream (master side)
//   halt_cause_o        : {breakpoint, budget}
//   cycles_o            : cycles executed in the last run
//   done_o              : dump finished
module cpu_run_monitor
   import cpu_dbg_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int TRACE_DEPTH = 16,
   parameter int MAX_CYCLES  = 30,
   parameter int NUM_REGS    = 32,
   parameter int NUM_WATCH   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      halt_pc_en,
   input  logic [DATA_W-1:0]         halt_pc,
   input  logic [DATA_W-1:0]         pc_i,
   input  logic [DATA_W-1:0]         instr_i,
   output logic                      cpu_stall_o,
   output logic [4:0]                rf_raddr_o,
   input  logic [DATA_W-1:0]         rf_rdata_i,
   output logic [DATA_W-1:0]         dm_raddr_o,
   input  logic [DATA_W-1:0]         dm_rdata_i,
   input  logic [NUM_WATCH*DATA_W-1:0] watch_addr_i,
   cpu_run_monitor_if.master         dump,
   output logic [1:0]                halt_cause_o,
   output logic [15:0]               cycles_o,
   output logic                      done_o
);

   localparam int AW = $clog2(TRACE_DEPTH);
   localparam int CW = $clog2(TRACE_DEPTH + 1);

   state_e              state;
   logic [15:0]         idx;
   logic [CW-1:0]       tcount;
   logic [2*DATA_W-1:0] trdata;
   logic                arm, running, bud, bkp, fire;

   assign arm     = start && (state == ST_IDLE || state == ST_DONE);
   assign running = (state == ST_RUN);
   // Halt checks look at the entry being captured this edge.
   assign bud     = (cycles_o + 16'd1) == 16'(MAX_CYCLES);
   assign bkp     = halt_pc_en && (pc_i == halt_pc);
   assign fire    = dump.dump_valid_o && dump.dump_ready_i;

   trace_ring #(
      .DEPTH (TRACE_DEPTH),
      .WIDTH (2*DATA_W)
   ) u_ring (
      .clk    (clk),
      .rst    (rst),
      .clr    (arm),
      .we     (running),
      .wdata  ({pc_i, instr_i}),
      .rd_idx (idx[AW-1:0]),
      .rdata  (trdata),
      .count  (tcount)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         idx          <= '0;
         cycles_o     <= '0;
         halt_cause_o <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state        <= ST_RUN;
                  idx          <= '0;
                  cycles_o     <= '0;
                  halt_cause_o <= '0;
               end
            end
            ST_RUN: begin
               cycles_o <= cycles_o + 16'd1;
               if (bud || bkp) begin
                  halt_cause_o[HC_BUDGET] <= bud;
                  halt_cause_o[HC_BKPT]   <= bkp;
                  state <= ST_TDUMP;
                  idx   <= '0;
               end
            end
            // A halt always captures at least one entry, so count >= 1 here.
            ST_TDUMP: begin
               if (fire) begin
                  if (idx == 16'(tcount) - 16'd1) begin
                     state <= ST_RDUMP;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 16'd1;
                  end
               end
            end
            ST_RDUMP: begin
               if (fire) begin
                  if (idx == 16'(NUM_REGS - 1)) begin
                     state <= ST_MDUMP;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 16'd1;
                  end
               end
            end
            ST_MDUMP: begin
               if (fire) begin
                  if (idx == 16'(NUM_WATCH - 1)) begin
                     state <= ST_DONE;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 16'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Beat fields are pure functions of state/idx, so they hold while stalled.
   always_comb begin
      cpu_stall_o       = (state != ST_RUN);
      done_o            = (state == ST_DONE);
      dump.dump_valid_o = (state == ST_TDUMP) || (state == ST_RDUMP) ||
                          (state == ST_MDUMP);
      dump.dump_kind_o  = DK_TRACE;
      dump.dump_index_o = '0;
      dump.dump_data_o  = '0;
      rf_raddr_o        = '0;
      dm_raddr_o        = '0;
      case (state)
         ST_TDUMP: begin
            dump.dump_index_o = idx;
            dump.dump_data_o  = trdata;
         end
         ST_RDUMP: begin
            dump.dump_kind_o  = DK_REG;
            dump.dump_index_o = idx;
            rf_raddr_o        = idx[4:0];
            // R0 is architecturally zero whatever the RF model returns.
            dump.dump_data_o  = {{DATA_W{1'b0}},
                                 (idx == 16'd0) ? {DATA_W{1'b0}} : rf_rdata_i};
         end
         ST_MDUMP: begin
            dump.dump_kind_o  = DK_MEM;
            dump.dump_index_o = idx;
            for (int k = 0; k < NUM_WATCH; k++)
               if (idx == 16'(k))
                  dm_raddr_o = watch_addr_i[k*DATA_W +: DATA_W];
            dump.dump_data_o  = {{DATA_W{1'b0}}, dm_rdata_i};
         end
         default: ;
      endcase
   end

endmodule
